// File: rtl/mic_frame_packetizer_if.sv
// mic_frame_packetizer_if
//   Bundles the two streams around the packetizer.
//   mic_input_*    : per-channel samples from the mic front-end (valid only,
//                    no backpressure).
//   frame_output_* : packet stream toward the link path (ready/valid,
//                    readyLatency 0, SOP on header, EOP on last sample).
//   master : the packetizer side (consumes samples, drives packets).
//   slave  : the environment side (drives samples, consumes packets).
interface mic_frame_packetizer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int CHANNEL_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]    mic_input_data;
    logic [CHANNEL_WIDTH-1:0] mic_input_channel;
    logic [1:0]               mic_input_error;
    logic                     mic_input_valid;

    logic [DATA_WIDTH-1:0]    frame_output_data;
    logic                     frame_output_valid;
    logic                     frame_output_ready;
    logic                     frame_output_startofpacket;
    logic                     frame_output_endofpacket;

    modport master (
        input  mic_input_data, mic_input_channel, mic_input_error, mic_input_valid,
        input  frame_output_ready,
        output frame_output_data, frame_output_valid,
        output frame_output_startofpacket, frame_output_endofpacket
    );

    modport slave (
        output mic_input_data, mic_input_channel, mic_input_error, mic_input_valid,
        output frame_output_ready,
        input  frame_output_data, frame_output_valid,
        input  frame_output_startofpacket, frame_output_endofpacket
    );
endinterface

// File: rtl/mic_frame_packetizer.sv
// mic_frame_packetizer
//   Collects one frame of NUM_CHANNELS in-order samples into a ping-pong
//   buffer and emits it as a packet: a header word followed by the samples.
//   Ports:
//     clk, reset_n     : clock, asynchronous active-low reset
//     bus (master)     : mic sample input and packet output streams
//     clear_stats      : synchronous clear of counters and sticky flag
//     frame_count      : packets fully emitted, saturating
//     dropped_frames   : complete frames discarded for lack of a bank, saturating
//     seq_error_count  : channel-order violations, saturating
//     seq_error        : sticky order-violation flag
//   Header word: [31:16] HEADER_MAGIC, [15] bank error flag, [14:12] 0,
//   [11:0] sequence number.
module mic_frame_packetizer #(
    parameter int          NUM_CHANNELS  = 16,
    parameter int          DATA_WIDTH    = 32,
    parameter int          CHANNEL_WIDTH = 4,
    parameter logic [15:0] HEADER_MAGIC  = 16'hA5C3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mic_frame_packetizer_if.master bus,
    input  logic                   clear_stats,
    output logic [15:0]            frame_count,
    output logic [15:0]            dropped_frames,
    output logic [15:0]            seq_error_count,
    output logic                   seq_error
);
    localparam int IDX_W = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    logic [1:0][NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [1:0]               full_q, full_d;
    logic [1:0]               err_q, err_d;
    logic                     fill_bank_q, fill_bank_d;
    logic [CHANNEL_WIDTH-1:0] exp_q, exp_d;

    state_t                   state_q, state_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;
    logic [11:0]              seq_q, seq_d;

    logic [15:0]              frame_count_q, frame_count_d;
    logic [15:0]              dropped_q, dropped_d;
    logic [15:0]              seq_err_cnt_q, seq_err_cnt_d;
    logic                     seq_error_q, seq_error_d;

    logic                     other_bank;
    logic                     fire;
    logic                     rel_now;
    logic                     err_now;

    always_comb begin
        mem_d         = mem_q;
        full_d        = full_q;
        err_d         = err_q;
        fill_bank_d   = fill_bank_q;
        exp_d         = exp_q;
        state_d       = state_q;
        rd_bank_d     = rd_bank_q;
        rd_idx_d      = rd_idx_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        seq_d         = seq_q;
        frame_count_d = frame_count_q;
        dropped_d     = dropped_q;
        seq_err_cnt_d = seq_err_cnt_q;
        seq_error_d   = seq_error_q;
        rel_now       = 1'b0;
        err_now       = 1'b0;
        other_bank    = ~fill_bank_q;
        fire          = out_valid_q & bus.frame_output_ready;

        // Output side. The fill bank is never full, so a full bank is always
        // the one opposite the fill pointer.
        case (state_q)
            IDLE: begin
                if (full_q[other_bank]) begin
                    rd_bank_d   = other_bank;
                    out_data_d  = DATA_WIDTH'({HEADER_MAGIC, err_q[other_bank], 3'b000, seq_q});
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b1;
                    out_eop_d   = 1'b0;
                    state_d     = HEADER;
                end
            end
            HEADER: begin
                if (fire) begin
                    out_data_d = mem_q[rd_bank_q][0];
                    out_sop_d  = 1'b0;
                    out_eop_d  = 1'b0;
                    rd_idx_d   = IDX_W'(1);
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (fire) begin
                    if (out_eop_q) begin
                        out_valid_d = 1'b0;
                        out_eop_d   = 1'b0;
                        rel_now     = 1'b1;
                        seq_d       = seq_q + 12'd1;
                        if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
                        state_d     = IDLE;
                    end else begin
                        out_data_d = mem_q[rd_bank_q][rd_idx_q];
                        out_eop_d  = (rd_idx_q == IDX_W'(NUM_CHANNELS - 1));
                        rd_idx_d   = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel_now) full_d[rd_bank_q] = 1'b0;

        // Fill side.
        if (bus.mic_input_valid) begin
            if (bus.mic_input_channel == exp_q) begin
                mem_d[fill_bank_q][exp_q[IDX_W-1:0]] = bus.mic_input_data;
                err_now = err_q[fill_bank_q] | (bus.mic_input_error != 2'b00);
                err_d[fill_bank_q] = err_now;
                if (exp_q == CHANNEL_WIDTH'(NUM_CHANNELS - 1)) begin
                    exp_d = '0;
                    // A bank released on this same edge already counts as free.
                    if (!full_q[other_bank] || (rel_now && rd_bank_q == other_bank)) begin
                        full_d[fill_bank_q] = 1'b1;
                        fill_bank_d         = other_bank;
                        err_d[other_bank]   = 1'b0;
                    end else begin
                        err_d[fill_bank_q] = 1'b0;
                        if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
                    end
                end else begin
                    exp_d = exp_q + 1'b1;
                end
            end else begin
                // Out-of-order sample aborts the partial frame; a channel 0
                // restarts a new frame rather than being thrown away.
                seq_error_d = 1'b1;
                if (seq_err_cnt_q != 16'hFFFF) seq_err_cnt_d = seq_err_cnt_q + 16'd1;
                if (bus.mic_input_channel == '0) begin
                    mem_d[fill_bank_q][0] = bus.mic_input_data;
                    err_d[fill_bank_q]    = (bus.mic_input_error != 2'b00);
                    exp_d                 = CHANNEL_WIDTH'(1);
                end else begin
                    err_d[fill_bank_q] = 1'b0;
                    exp_d              = '0;
                end
            end
        end

        if (clear_stats) begin
            frame_count_d = '0;
            dropped_d     = '0;
            seq_err_cnt_d = '0;
            seq_error_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q         <= '0;
            full_q        <= '0;
            err_q         <= '0;
            fill_bank_q   <= 1'b0;
            exp_q         <= '0;
            state_q       <= IDLE;
            rd_bank_q     <= 1'b0;
            rd_idx_q      <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            seq_q         <= '0;
            frame_count_q <= '0;
            dropped_q     <= '0;
            seq_err_cnt_q <= '0;
            seq_error_q   <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            full_q        <= full_d;
            err_q         <= err_d;
            fill_bank_q   <= fill_bank_d;
            exp_q         <= exp_d;
            state_q       <= state_d;
            rd_bank_q     <= rd_bank_d;
            rd_idx_q      <= rd_idx_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            seq_q         <= seq_d;
            frame_count_q <= frame_count_d;
            dropped_q     <= dropped_d;
            seq_err_cnt_q <= seq_err_cnt_d;
            seq_error_q   <= seq_error_d;
        end
    end

    assign bus.frame_output_data          = out_data_q;
    assign bus.frame_output_valid         = out_valid_q;
    assign bus.frame_output_startofpacket = out_sop_q;
    assign bus.frame_output_endofpacket   = out_eop_q;
    assign frame_count                    = frame_count_q;
    assign dropped_frames                 = dropped_q;
    assign seq_error_count                = seq_err_cnt_q;
    assign seq_error                      = seq_error_q;
endmodule

// File: tb/tb_mic_frame_packetizer.sv
// tb_mic_frame_packetizer
//   Directed bench for mic_frame_packetizer. Inputs change 1 time unit after
//   the rising edge; outputs are captured on the falling edge into a queue of
//   {sop, eop, data} words and compared against hand-built packets.
module tb_mic_frame_packetizer;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        clear_stats = 1'b0;
    logic [15:0] frame_count, dropped_frames, seq_error_count;
    logic        seq_error;
    logic        rnd_en = 1'b0;

    int errs = 0;
    int checks = 0;

    mic_frame_packetizer_if #(.DATA_WIDTH(32), .CHANNEL_WIDTH(4)) bus ();

    mic_frame_packetizer #(.NUM_CHANNELS(N)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .clear_stats     (clear_stats),
        .frame_count     (frame_count),
        .dropped_frames  (dropped_frames),
        .seq_error_count (seq_error_count),
        .seq_error       (seq_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output capture plus hold-stable check during stalls.
    logic [33:0] q[$];
    logic [33:0] mon_w;
    logic [33:0] prev_w = '0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    assign mon_w = {bus.frame_output_startofpacket, bus.frame_output_endofpacket, bus.frame_output_data};

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_v && !prev_r) begin
                chk("stall_valid", 64'(bus.frame_output_valid), 64'd1);
                chk("stall_word", 64'(mon_w), 64'(prev_w));
            end
            if (bus.frame_output_valid && bus.frame_output_ready) q.push_back(mon_w);
        end
        prev_v = reset_n & bus.frame_output_valid;
        prev_r = bus.frame_output_ready;
        prev_w = mon_w;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_en) bus.frame_output_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic smp(input int ch, input logic [31:0] d, input logic [1:0] e);
        bus.mic_input_channel = 4'(ch);
        bus.mic_input_data    = d;
        bus.mic_input_error   = e;
        bus.mic_input_valid   = 1'b1;
        step();
        bus.mic_input_valid   = 1'b0;
        bus.mic_input_error   = 2'b00;
    endtask

    task automatic frame(input logic [31:0] base, input int ech, input logic [1:0] e);
        for (int c = 0; c < N; c++) smp(c, base + 32'(c), (c == ech) ? e : 2'b00);
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("word_timeout", 64'(q.size() >= n), 64'd1);
    endtask

    task automatic pop_chk(input string tag, input logic [33:0] exp);
        logic [33:0] w;
        w = '1;
        if (q.size() > 0) w = q.pop_front();
        chk(tag, 64'(w), 64'(exp));
    endtask

    task automatic check_pkt(input logic [31:0] hdr, input logic [31:0] base);
        wait_words(N + 1, 600);
        pop_chk("hdr", {2'b10, hdr});
        for (int i = 1; i <= N; i++) pop_chk("word", {1'b0, (i == N), base + 32'(i - 1)});
    endtask

    task automatic do_reset();
        bus.mic_input_valid = 1'b0;
        clear_stats = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_out", 64'({bus.frame_output_valid, bus.frame_output_startofpacket,
                            bus.frame_output_endofpacket, seq_error, bus.frame_output_data}), 64'd0);
        chk("rst_cnt", 64'({frame_count, dropped_frames, seq_error_count}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
    endtask

    initial begin
        bus.mic_input_data = '0;
        bus.mic_input_channel = '0;
        bus.mic_input_error = 2'b00;
        bus.mic_input_valid = 1'b0;
        bus.frame_output_ready = 1'b1;
        #3;

        // 1: single frame, latency and content
        do_reset();
        frame(32'h1000, -1, 2'b00);
        chk("lat_edge", 64'(bus.frame_output_valid), 64'd0);
        step();
        chk("lat_next", 64'({bus.frame_output_valid, bus.frame_output_startofpacket}), 64'd3);
        check_pkt(32'hA5C3_0000, 32'h1000);
        chk("fc1", 64'(frame_count), 64'd1);

        // 2: stalled sink, frames arriving while a bank is still draining
        bus.frame_output_ready = 1'b0;
        do_reset();
        frame(32'h2000, -1, 2'b00);
        frame(32'h2100, -1, 2'b00);
        frame(32'h2200, -1, 2'b00);
        chk("drop2", 64'(dropped_frames), 64'd2);
        chk("stall_hdr", 64'({bus.frame_output_valid, bus.frame_output_startofpacket, bus.frame_output_data}),
            64'({2'b11, 32'hA5C3_0000}));
        bus.frame_output_ready = 1'b1;
        check_pkt(32'hA5C3_0000, 32'h2000);
        frame(32'h2300, -1, 2'b00);
        check_pkt(32'hA5C3_0001, 32'h2300);

        // 3: order violation then clean run
        do_reset();
        smp(0, 32'h3000, 2'b00);
        smp(1, 32'h3001, 2'b00);
        smp(2, 32'h3002, 2'b00);
        smp(5, 32'h3005, 2'b00);
        chk("seqerr", 64'({seq_error, seq_error_count}), 64'({1'b1, 16'd1}));
        frame(32'h3000, -1, 2'b00);
        check_pkt(32'hA5C3_0000, 32'h3000);

        // 4: error flag in header, cleared on the next frame
        frame(32'h4000, 7, 2'b01);
        check_pkt(32'hA5C3_8001, 32'h4000);
        frame(32'h4100, -1, 2'b00);
        check_pkt(32'hA5C3_0002, 32'h4100);
        repeat (30) step();
        chk("no_extra", 64'(q.size()), 64'd0);
        chk("fc3", 64'({frame_count, seq_error_count}), 64'({16'd3, 16'd1}));

        // 5: random ready over 50 frames
        do_reset();
        rnd_en = 1'b1;
        for (int f = 0; f < 50; f++) begin
            frame(32'h5000 + 32'(f * 256), -1, 2'b00);
            check_pkt({16'hA5C3, 4'h0, 12'(f)}, 32'h5000 + 32'(f * 256));
        end
        rnd_en = 1'b0;
        bus.frame_output_ready = 1'b1;
        repeat (4) step();
        chk("fc50", 64'({frame_count, dropped_frames}), 64'({16'd50, 16'd0}));

        // 6: clear_stats on a dropping completion, then reset mid-packet
        bus.frame_output_ready = 1'b0;
        do_reset();
        frame(32'h6000, -1, 2'b00);
        frame(32'h6100, -1, 2'b00);
        chk("drop1", 64'(dropped_frames), 64'd1);
        smp(0, 32'h6200, 2'b00);
        smp(3, 32'h6203, 2'b00);
        chk("seqerr6", 64'({seq_error, seq_error_count}), 64'({1'b1, 16'd1}));
        for (int c = 0; c < N - 1; c++) smp(c, 32'h6300 + 32'(c), 2'b00);
        clear_stats = 1'b1;
        smp(N - 1, 32'h630F, 2'b00);
        clear_stats = 1'b0;
        chk("clr", 64'({dropped_frames, seq_error_count, seq_error}), 64'd0);
        bus.frame_output_ready = 1'b1;
        wait_words(3, 50);
        pop_chk("hdr6", {2'b10, 32'hA5C3_0000});
        pop_chk("w6_0", {2'b00, 32'h6000});
        pop_chk("w6_1", {2'b00, 32'h6001});
        do_reset();
        repeat (30) step();
        chk("post_rst", 64'({q.size() != 0, bus.frame_output_valid}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end
endmodule
